// File: rtl/mem_req_arbiter.sv
// Dual-channel round-robin arbiter with in-order tag FIFOs that route memory acks back to their requesters.
// Optional build macro MEM_ARB_RET_CHECK_EN adds ack address checking that drives a sticky ret_error.

module mem_req_arbiter_fifo #(
   parameter int W     = 4,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [PW-1:0] wp, rp;
   logic [PW:0]   cnt;

   assign dout  = mem[rp];
   assign empty = (cnt == '0);
   assign full  = (cnt == (PW+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         if (push && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !push) cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= din;
   end
endmodule

module mem_req_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int AW        = 16,
   parameter int DW        = 16,
   parameter int OUT_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [NUM_REQ*AW-1:0] req_address,
   input  logic [NUM_REQ*DW-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    wr_resp_valid,
   output logic [AW-1:0]         wr_resp_address,
   output logic [NUM_REQ-1:0]    rd_resp_valid,
   output logic [AW-1:0]         rd_resp_address,
   output logic [DW-1:0]         rd_resp_data,
   output logic [AW-1:0]         wr_address,
   output logic [DW-1:0]         wr_data,
   output logic                  wr_en,
   input  logic [AW-1:0]         wr_ret_address,
   input  logic                  wr_ret_ack,
   output logic [AW-1:0]         rd_address,
   output logic                  rd_en,
   input  logic [DW-1:0]         rd_ret_data,
   input  logic [AW-1:0]         rd_ret_address,
   input  logic                  rd_ret_ack,
   output logic                  ret_error
);
   localparam int IDW = $clog2(NUM_REQ);
`ifdef MEM_ARB_RET_CHECK_EN
   localparam int TW = IDW + AW;
`else
   localparam int TW = IDW;
`endif

   logic [NUM_REQ-1:0][AW-1:0] addr_a;
   logic [NUM_REQ-1:0][DW-1:0] data_a;
   assign addr_a = req_address;
   assign data_a = req_data;

   // Rotate candidates so index 0 is the pointer, then take the first set bit.
   function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                            input logic [IDW-1:0] ptr);
      logic [2*NUM_REQ-1:0] rot;
      logic                 found;
      logic [IDW-1:0]       sel;
      int                   s;
      rot   = {cand, cand} >> ptr;
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            s = int'(ptr) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            sel = IDW'(s);
         end
      end
      return {found, sel};
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
      return {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
   endfunction

   function automatic logic [IDW-1:0] ptr_next(input logic [IDW-1:0] id);
      return (id == IDW'(NUM_REQ-1)) ? '0 : id + 1'b1;
   endfunction

   logic [IDW-1:0] wr_ptr, rd_ptr, wr_win, rd_win;
   logic           wr_found, rd_found, wr_xfer, rd_xfer, wr_pop, rd_pop;
   logic           wr_full, rd_full, wr_empty, rd_empty;
   logic [TW-1:0]  wr_tag, rd_tag, wr_head, rd_head;

   always_comb begin
      {wr_found, wr_win} = rr_pick(req_valid & req_write, wr_ptr);
      {rd_found, rd_win} = rr_pick(req_valid & ~req_write, rd_ptr);
   end

   // A full FIFO blocks grants even when a pop lands in the same cycle.
   assign wr_xfer   = wr_found & ~wr_full & ~reset;
   assign rd_xfer   = rd_found & ~rd_full & ~reset;
   assign req_ready = (wr_xfer ? onehot(wr_win) : '0) | (rd_xfer ? onehot(rd_win) : '0);
   assign wr_pop    = wr_ret_ack & ~wr_empty;
   assign rd_pop    = rd_ret_ack & ~rd_empty;

`ifdef MEM_ARB_RET_CHECK_EN
   assign wr_tag = {addr_a[wr_win], wr_win};
   assign rd_tag = {addr_a[rd_win], rd_win};
`else
   assign wr_tag = wr_win;
   assign rd_tag = rd_win;
`endif

   mem_req_arbiter_fifo #(.W(TW), .DEPTH(OUT_DEPTH)) u_wr_fifo (
      .clk(clk), .reset(reset), .push(wr_xfer), .din(wr_tag), .pop(wr_pop),
      .dout(wr_head), .empty(wr_empty), .full(wr_full)
   );

   mem_req_arbiter_fifo #(.W(TW), .DEPTH(OUT_DEPTH)) u_rd_fifo (
      .clk(clk), .reset(reset), .push(rd_xfer), .din(rd_tag), .pop(rd_pop),
      .dout(rd_head), .empty(rd_empty), .full(rd_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         wr_en           <= 1'b0;
         rd_en           <= 1'b0;
         wr_address      <= '0;
         wr_data         <= '0;
         rd_address      <= '0;
         wr_resp_valid   <= '0;
         wr_resp_address <= '0;
         rd_resp_valid   <= '0;
         rd_resp_address <= '0;
         rd_resp_data    <= '0;
      end else begin
         wr_en <= wr_xfer;
         if (wr_xfer) begin
            wr_address <= addr_a[wr_win];
            wr_data    <= data_a[wr_win];
            wr_ptr     <= ptr_next(wr_win);
         end
         rd_en <= rd_xfer;
         if (rd_xfer) begin
            rd_address <= addr_a[rd_win];
            rd_ptr     <= ptr_next(rd_win);
         end
         wr_resp_valid <= wr_pop ? onehot(wr_head[IDW-1:0]) : '0;
         if (wr_pop) wr_resp_address <= wr_ret_address;
         rd_resp_valid <= rd_pop ? onehot(rd_head[IDW-1:0]) : '0;
         if (rd_pop) begin
            rd_resp_address <= rd_ret_address;
            rd_resp_data    <= rd_ret_data;
         end
      end
   end

`ifdef MEM_ARB_RET_CHECK_EN
   logic err_q, wr_bad, rd_bad;
   assign wr_bad = wr_ret_ack & (wr_empty | (wr_head[TW-1:IDW] != wr_ret_address));
   assign rd_bad = rd_ret_ack & (rd_empty | (rd_head[TW-1:IDW] != rd_ret_address));

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_q | wr_bad | rd_bad;
   end
   assign ret_error = err_q;
`else
   assign ret_error = 1'b0;
`endif
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: round-robin order, dual-channel grants, FIFO full/ordering, reset flush, ret checking.
module tb_mem_req_arbiter;
   localparam int N = 4;
   localparam int AW = 16;
   localparam int DW = 16;
`ifdef MEM_ARB_RET_CHECK_EN
   localparam logic [31:0] EN = 1;
`else
   localparam logic [31:0] EN = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic [N-1:0]    req_valid, req_write, req_ready;
   logic [N*AW-1:0] req_address;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    wr_resp_valid, rd_resp_valid;
   logic [AW-1:0]   wr_resp_address, rd_resp_address, wr_address, rd_address;
   logic [AW-1:0]   wr_ret_address, rd_ret_address;
   logic [DW-1:0]   rd_resp_data, wr_data, rd_ret_data;
   logic            wr_en, rd_en, wr_ret_ack, rd_ret_ack, ret_error;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_req_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .OUT_DEPTH(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_address(req_address), .req_data(req_data),
      .req_ready(req_ready),
      .wr_resp_valid(wr_resp_valid), .wr_resp_address(wr_resp_address),
      .rd_resp_valid(rd_resp_valid), .rd_resp_address(rd_resp_address), .rd_resp_data(rd_resp_data),
      .wr_address(wr_address), .wr_data(wr_data), .wr_en(wr_en),
      .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
      .rd_address(rd_address), .rd_en(rd_en),
      .rd_ret_data(rd_ret_data), .rd_ret_address(rd_ret_address), .rd_ret_ack(rd_ret_ack),
      .ret_error(ret_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      req_valid = '0; req_write = '0; req_address = '0; req_data = '0;
      wr_ret_address = '0; wr_ret_ack = 1'b0;
      rd_ret_address = '0; rd_ret_data = '0; rd_ret_ack = 1'b0;
      tick(); tick();
      chk("rst_ready", req_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_resp", wr_resp_valid, 0);
      chk("rst_rd_resp", rd_resp_valid, 0);
      chk("rst_wr_addr", wr_address, 0);
      chk("rst_rd_addr", rd_address, 0);
      chk("rst_rd_data", rd_resp_data, 0);
      chk("rst_err", ret_error, 0);
      reset = 1'b0;

      // round-robin reads from all four requesters
      req_address = {16'h13, 16'h12, 16'h11, 16'h10};
      req_write = 4'b0000;
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rr_ready", req_ready, 32'(1) << k);
         tick();
         chk("rr_rd_en", rd_en, 1);
         chk("rr_rd_addr", rd_address, 32'h10 + k);
      end
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         rd_ret_ack = 1'b1;
         rd_ret_address = 16'(16'h10 + k);
         rd_ret_data = 16'(16'hD0 + k);
         tick();
         chk("rr_resp_vld", rd_resp_valid, 32'(1) << k);
         chk("rr_resp_addr", rd_resp_address, 32'h10 + k);
         chk("rr_resp_data", rd_resp_data, 32'hD0 + k);
      end
      rd_ret_ack = 1'b0;
      tick();
      chk("rr_resp_idle", rd_resp_valid, 0);
      chk("rr_rd_en_idle", rd_en, 0);

      // simultaneous write (req1) and read (req2)
      req_address = {16'h13, 16'h0007, 16'h0005, 16'h10};
      req_data = {16'h0, 16'h0, 16'hBEEF, 16'h0};
      req_write = 4'b0010;
      req_valid = 4'b0110;
      #1;
      chk("dual_ready", req_ready, 4'b0110);
      tick();
      req_valid = '0;
      chk("dual_wr_en", wr_en, 1);
      chk("dual_wr_addr", wr_address, 16'h0005);
      chk("dual_wr_data", wr_data, 16'hBEEF);
      chk("dual_rd_en", rd_en, 1);
      chk("dual_rd_addr", rd_address, 16'h0007);
      wr_ret_ack = 1'b1; wr_ret_address = 16'h0005;
      rd_ret_ack = 1'b1; rd_ret_address = 16'h0007; rd_ret_data = 16'h1234;
      tick();
      wr_ret_ack = 1'b0; rd_ret_ack = 1'b0;
      chk("dual_wr_resp", wr_resp_valid, 4'b0010);
      chk("dual_wr_resp_addr", wr_resp_address, 16'h0005);
      chk("dual_rd_resp", rd_resp_valid, 4'b0100);
      chk("dual_rd_resp_data", rd_resp_data, 16'h1234);
      chk("dual_wr_en_idle", wr_en, 0);

      // fill the read FIFO (pointer now at 3) with acks held off
      req_address = {16'h13, 16'h12, 16'h11, 16'h10};
      req_write = 4'b0000;
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk("fill_ready", req_ready, 32'(1) << ((3 + k) % 4));
         tick();
      end
      chk("full_ready", req_ready, 0);
      chk("full_rd_en", rd_en, 1);
      chk("full_rd_addr", rd_address, 16'h12);
      tick();
      chk("full_ready2", req_ready, 0);
      chk("full_rd_en2", rd_en, 0);
      for (int k = 0; k < 8; k++) begin
         int id;
         id = (3 + k) % 4;
         rd_ret_ack = 1'b1;
         rd_ret_address = 16'(16'h10 + id);
         rd_ret_data = 16'(16'hA0 + k);
         if (k == 0) begin
            #1;
            chk("no_bypass", req_ready, 0);
            req_valid = '0;
         end
         tick();
         chk("drain_vld", rd_resp_valid, 32'(1) << id);
         chk("drain_data", rd_resp_data, 32'hA0 + k);
      end
      rd_ret_ack = 1'b0;

      // push and pop together with three entries held
      req_valid = 4'b1111;
      #1;
      chk("pp_ready0", req_ready, 4'b1000);
      tick();
      chk("pp_ready1", req_ready, 4'b0001);
      tick();
      chk("pp_ready2", req_ready, 4'b0010);
      tick();
      chk("pp_ready3", req_ready, 4'b0100);
      rd_ret_ack = 1'b1; rd_ret_address = 16'h13; rd_ret_data = 16'h55;
      tick();
      req_valid = '0;
      chk("pp_resp", rd_resp_valid, 4'b1000);
      chk("pp_resp_data", rd_resp_data, 16'h55);
      chk("pp_rd_en", rd_en, 1);
      chk("pp_rd_addr", rd_address, 16'h12);
      for (int k = 0; k < 3; k++) begin
         rd_ret_address = 16'(16'h10 + k);
         rd_ret_data = 16'(16'h56 + k);
         tick();
         chk("pp_rest", rd_resp_valid, 32'(1) << k);
      end
      chk("pp_err_clean", ret_error, 0);
      rd_ret_address = 16'h99;
      tick();
      rd_ret_ack = 1'b0;
      chk("empty_ack", rd_resp_valid, 0);
      chk("empty_ack_err", ret_error, EN);

      // reset with four reads outstanding
      req_valid = 4'b1111;
      tick(); tick(); tick(); tick();
      req_valid = '0;
      reset = 1'b1;
      tick();
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_rd_en", rd_en, 0);
      chk("mid_rst_rd_addr", rd_address, 0);
      chk("mid_rst_resp", rd_resp_valid, 0);
      chk("mid_rst_resp_addr", rd_resp_address, 0);
      chk("mid_rst_err", ret_error, 0);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rd_ret_ack = 1'b1;
         rd_ret_address = 16'(16'h10 + ((3 + k) % 4));
         tick();
         chk("stale_ack", rd_resp_valid, 0);
      end
      rd_ret_ack = 1'b0;
      chk("stale_err", ret_error, EN);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_clear_err", ret_error, 0);

      // address mismatch on return
      req_address = {16'h13, 16'h12, 16'h11, 16'h0020};
      req_valid = 4'b0001;
      #1;
      chk("mm_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      chk("mm_rd_addr", rd_address, 16'h0020);
      rd_ret_ack = 1'b1; rd_ret_address = 16'h0021; rd_ret_data = 16'h77;
      tick();
      rd_ret_ack = 1'b0;
      chk("mm_resp", rd_resp_valid, 4'b0001);
      chk("mm_resp_addr", rd_resp_address, 16'h0021);
      chk("mm_err", ret_error, EN);
      tick(); tick();
      chk("mm_err_sticky", ret_error, EN);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one memory_controller between NUM_REQ requesters.
- Runs two independent round-robin arbiters, one for the write channel and one for the read channel, and drives the controller's wr_*/rd_* ports from registers.
- Tracks outstanding requests per channel in in-order tag FIFOs, so each wr_ret_ack/rd_ret_ack is routed back to the requester that issued it.
- Sits between client logic and memory_controller in top-level integration.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- AW, 16: address width.
- DW, 16: data width.
- OUT_DEPTH, 8: outstanding-request FIFO depth per channel; must be a power of 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_write  input  NUM_REQ  1 = write request, 0 = read request.
- req_address  input  NUM_REQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
- req_data  input  NUM_REQ*DW  packed write data; same packing as req_address.
- req_ready  output  NUM_REQ  grant; the transfer occurs when req_valid[i] & req_ready[i].
- wr_resp_valid  output  NUM_REQ  one-hot write-ack strobe.
- wr_resp_address  output  AW  address of the acked write.
- rd_resp_valid  output  NUM_REQ  one-hot read-data strobe.
- rd_resp_address  output  AW  address of the returned read.
- rd_resp_data  output  DW  returned read data.
- wr_address, wr_data  output  AW, DW  to memory_controller.
- wr_en  output  1  to memory_controller.
- wr_ret_address  input  AW  from memory_controller.
- wr_ret_ack  input  1  from memory_controller.
- rd_address  output  AW  to memory_controller.
- rd_en  output  1  to memory_controller.
- rd_ret_data, rd_ret_address  input  DW, AW  from memory_controller.
- rd_ret_ack  input  1  from memory_controller.
- ret_error  output  1  sticky return-mismatch flag; always 0 without RET_CHECK_EN.

Behaviour:
- **Reset**
  - Applies on the clk edge when reset=1.
  - All outputs go to 0, both FIFOs empty, both round-robin pointers go to 0.
  - Reset mid-operation discards every in-flight tag. Returns arriving after reset see an empty FIFO: they are dropped and no resp strobe fires.
- **Channel split**
  - A requester's request competes only on the channel selected by req_write[i].
  - The write and read arbiters each issue at most one grant per cycle.
  - Both channels may grant in the same cycle, to different requesters.
- **Arbitration (per channel, combinational req_ready)**
  - Candidates: requesters with req_valid=1 whose req_write matches the channel.
  - Search order starts at the channel pointer ptr and proceeds ptr, ptr+1, ... modulo NUM_REQ; the first candidate found wins.
  - No grant is issued while that channel's FIFO is full. This holds even if a return pops in the same cycle (no bypass).
  - On a transfer from requester i, ptr becomes (i+1) mod NUM_REQ. With no transfer, ptr holds.
- **Issue (1-cycle latency)**
  - On the edge after a write transfer: wr_en=1, with wr_address/wr_data taken from the winner.
  - In all other cycles wr_en=0; wr_address/wr_data hold their last values.
  - The read channel behaves the same with rd_en/rd_address.
  - On the transfer edge, {requester id, address} is pushed into that channel's FIFO.
- **Return routing**
  - memory_controller returns acks in issue order per channel.
  - On wr_ret_ack=1 with the FIFO non-empty: pop the entry. On the next edge, wr_resp_valid = one-hot(id) for one cycle, and wr_resp_address = wr_ret_address.
  - The read channel is identical; rd_resp_data is registered from rd_ret_data.
  - An ack with the FIFO empty is ignored and produces no strobe.
  - Push and pop in the same cycle are both performed; the count is unchanged.
- **FIFO**
  - Count width is log2(OUT_DEPTH)+1.
  - Read/write pointers wrap modulo OUT_DEPTH.

Optional Feature:
- Macro: MEM_ARB_RET_CHECK_EN.
- With the macro defined, each FIFO entry's stored address is compared against the ret_address of the popping ack. ret_error is set to 1 (sticky until reset) on either of:
  - an address mismatch;
  - an ack arriving while the FIFO is empty.
- ret_error is registered, so it asserts on the edge after the offending ack.
- Without the macro, no compare logic is built and ret_error is tied to 0.

Test Plan:
- After reset: all four requesters assert read requests to addresses 0x10–0x13 continuously → grants in order 0,1,2,3,0...; rd_en=1 with rd_address=0x10 exactly one cycle after req0's grant.
- Requester 1 writes 0x0005/data 0xBEEF while requester 2 reads 0x0007 in the same cycle → both granted; wr_en and rd_en both 1 on the next edge.
- Hold rd_ret_ack=0 and issue 8 reads → ready drops to 0 after the 8th. Then 8 acks → the rd_resp_valid one-hots match the issue order and rd_resp_data echoes rd_ret_data.
- FIFO holding 3 entries, with a new push and an rd_ret_ack in the same cycle → count stays 3 and the routed requester is the oldest entry.
- Assert reset with 4 reads outstanding → all outputs are 0. The 4 later acks produce no rd_resp_valid, and ret_error=1 when MEM_ARB_RET_CHECK_EN is defined.
- With MEM_ARB_RET_CHECK_EN defined: issue a read to 0x0020 and return rd_ret_address=0x0021 → ret_error=1 on the next edge, held until reset.
